sp_memory_req_adapter: RTL
==========================

// Module: sp_memory_req_adapter
// PURPOSE
//  Valid/ready front end that sits directly upstream of sp_memory. Accepts requests from a bus-side master,
//  drives sp_memory cs/we/addr/wdata/wstrb, absorbs its 1-cycle synchronous read latency and returns
//  responses in request order through a buffered valid/ready channel that tolerates backpressure.
// PARAMETERS
//  WIDTH      32   data width; multiple of 8, matches sp_memory WIDTH
//  DEPTH      256  memory depth in words; address width AW = $clog2(DEPTH)
//  RSP_DEPTH  4    response FIFO entries; must be >= 3 for one request per cycle with rsp_ready held high
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        asynchronous active-low reset
//  req_valid      in   1        request present
//  req_ready      out  1        adapter accepts request this cycle
//  req_we         in   1        1 = write, 0 = read
//  req_addr       in   AW       word address
//  req_wdata      in   WIDTH    write data
//  req_wstrb      in   WIDTH/8  byte enables (writes only)
//  rsp_valid      out  1        response present
//  rsp_ready      in   1        consumer accepts response
//  rsp_we         out  1        1 = write acknowledge, 0 = read data
//  rsp_rdata      out  WIDTH    read data; all-zero for write acks
//  rsp_err        out  2        {ecc_double, ecc_single|parity}; 2'b00 for write acks
//  mem_cs         out  1        to sp_memory cs
//  mem_we         out  1        to sp_memory we
//  mem_addr       out  AW       to sp_memory addr
//  mem_wdata      out  WIDTH    to sp_memory wdata
//  mem_wstrb      out  WIDTH/8  to sp_memory wstrb
//  mem_rdata      in   WIDTH    from sp_memory rdata
//  mem_err        in   3        from sp_memory {err_ecc_double, err_ecc_single, err_parity}
//  busy           out  1        in-flight access or response FIFO non-empty
// BEHAVIOUR
//  - Reset (async, rst_n low): FIFO flushed, in-flight flag cleared; req_ready=0, rsp_valid=0, mem_cs=0,
//    mem_we=0, busy=0, rsp_* data=0. Reset mid-operation discards in-flight access and queued responses.
//  - Credits: occ = FIFO occupancy (registered), infl = 1 if an access was issued last cycle.
//    req_ready = rst_n & ((occ + infl) < RSP_DEPTH); no combinational path from rsp_ready or req_valid.
//  - Issue: fire = req_valid & req_ready. mem_cs = fire; mem_we = fire & req_we; mem_addr/wdata/wstrb are
//    combinational copies of req_* (mem_wstrb forced 0 when not a write). Zero added latency to memory.
//  - Cycle N+1 after fire: push one entry {we, data, err}: read -> mem_rdata and mapped mem_err;
//    write -> data 0, err 0. Exactly one response per accepted request, strictly in order.
//  - Response FIFO: circular, wr/rd pointers wrap at RSP_DEPTH; rsp_* driven from head entry (registered
//    storage); pop when rsp_valid & rsp_ready. Simultaneous push and pop leaves occ unchanged.
//  - Credit rule guarantees a push never meets a full FIFO; overflow impossible by construction (assert).
//  - Request-to-response latency: 2 cycles minimum (fire at N, rsp_valid at N+2) when FIFO empty.
//  - Throughput: 1 request/cycle sustained while rsp_ready=1 and RSP_DEPTH>=3.
//  - Full backpressure: after occ+infl reaches RSP_DEPTH, req_ready=0 until a pop; first pop re-opens
//    req_ready on the following cycle.
//  - Read-after-write to same address in consecutive cycles returns the new data (memory write-first order
//    by issue sequence; write completes at its edge before the read is sampled next edge).
//  - busy = infl | (occ != 0).
// TESTING
//  1. Reset: hold rst_n=0 with req_valid=1 -> req_ready=0, mem_cs=0, rsp_valid=0 throughout.
//  2. Write 0x10=DEADBEEF strb 4'hF, then read 0x10 -> write ack (rsp_we=1, data 0) then read data
//     DEADBEEF, err 2'b00, each rsp_valid 2 cycles after its fire.
//  3. Byte enables: write 0x30=12345678 strb F, 000000AA strb 1, BB000000 strb 8, read 0x30 -> 0xBB3456AA.
//  4. Back-to-back 8 reads of 0x00..0x07 (preloaded i*0x11111111), rsp_ready=1 -> req_ready never drops,
//     8 responses in order on consecutive cycles.
//  5. Backpressure: rsp_ready=0, 6 read requests -> exactly 4 accepted, req_ready=0 after; release
//     rsp_ready -> remaining 2 accepted, all 6 returned in order with correct data.
//  6. Reset asserted with 3 responses queued and 1 in flight -> rsp_valid=0 immediately, busy=0; after
//     release, a read of 0x20 returns correct data with no stale responses.

Source files
------------

// File: rtl/sp_memory_req_adapter.sv
// sp_memory_req_adapter
//   Valid/ready front end for sp_memory. It issues each accepted request to
//   the memory in the same cycle, absorbs the one-cycle read latency and
//   returns one response per request, in order, through a small response FIFO.
//   The FIFO tolerates backpressure on the response side.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we/addr/wdata/wstrb    request payload (wstrb only meaningful for writes)
//   rsp_valid/rsp_ready        response handshake
//   rsp_we/rdata/err           response payload (write acks carry zero data/err)
//   mem_cs/we/addr/wdata/wstrb to sp_memory
//   mem_rdata, mem_err         from sp_memory ({ecc_double, ecc_single, parity})
//   busy                       access in flight or responses queued
module sp_memory_req_adapter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned RSP_DEPTH = 4,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned SW       = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [SW-1:0]    req_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_we,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [SW-1:0]    mem_wstrb,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [2:0]       mem_err,
  output logic             busy
);

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  // Wide enough to hold RSP_DEPTH itself (occupancy plus in-flight credit).
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic             fire;
  logic             push;
  logic             pop;
  logic             infl;
  logic             infl_we;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    credits_used;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic             push_we;
  logic [WIDTH-1:0] push_data;
  logic [1:0]       push_err;

  logic             fifo_we   [RSP_DEPTH];
  logic [WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [1:0]       fifo_err  [RSP_DEPTH];

  // Credits come only from registered state, so req_ready has no path from
  // rsp_ready or req_valid.
  assign credits_used = occ + {{(CW-1){1'b0}}, infl};
  assign req_ready    = rst_n & (credits_used < CW'(RSP_DEPTH));
  assign fire         = req_valid & req_ready;

  assign mem_cs    = fire;
  assign mem_we    = fire & req_we;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;
  assign mem_wstrb = (fire & req_we) ? req_wstrb : '0;

  // The access issued last cycle completes now; its memory outputs are valid.
  assign push    = infl;
  assign push_we = infl_we;

  always_comb begin
    push_data = '0;
    push_err  = '0;
    if (!infl_we) begin
      push_data = mem_rdata;
      push_err  = {mem_err[2], mem_err[1] | mem_err[0]};
    end
  end

  assign rsp_valid = (occ != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_we    = fifo_we[rd_ptr];
  assign rsp_rdata = fifo_data[rd_ptr];
  assign rsp_err   = fifo_err[rd_ptr];

  assign busy = infl | (occ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl    <= 1'b0;
      infl_we <= 1'b0;
    end else begin
      infl    <= fire;
      infl_we <= fire & req_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_we[i]   <= 1'b0;
        fifo_data[i] <= '0;
        fifo_err[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_we[wr_ptr]   <= push_we;
        fifo_data[wr_ptr] <= push_data;
        fifo_err[wr_ptr]  <= push_err;
        wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // The credit rule reserves a slot for every issued access.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (occ == CW'(RSP_DEPTH))));

endmodule
